// File: rtl/cic_pkg.sv
// Shared helpers for the N-stage CIC decimator: register sizing and saturating resize.
package cic_pkg;

    localparam int unsigned SAT_W = 256;

    // Accumulator width that makes modulo wrap exact for the worst-case ratio.
    function automatic int unsigned cic_reg_width(input int unsigned data_w,
                                                  input int unsigned stages,
                                                  input int unsigned max_dec);
        return data_w + stages * unsigned'($clog2(max_dec));
    endfunction

    // Clamp a wide signed value into the signed range of out_w bits.
    function automatic logic signed [SAT_W-1:0] sat_trunc(input logic signed [SAT_W-1:0] x,
                                                          input int unsigned out_w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (SAT_W'(1) << (out_w - 1)) - SAT_W'(1);
        lo = ~hi;
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/cic_decimator_n_comb.sv
// One CIC differentiator stage; the delay register only advances on a valid input.
module cic_comb_stage #(
    parameter int unsigned WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] data_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] delay_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            delay_q   <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                data_out <= data_in - delay_q;
                delay_q  <= data_in;
            end
        end
    end

endmodule

// File: rtl/cic_decimator_n.sv
// Parametrised N-stage CIC decimator with runtime ratio, saturating gain and
// a single-entry valid/ready output register with a sticky overrun flag.
module cic_decimator_n
    import cic_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 12,
    parameter int unsigned NUM_STAGES     = 5,
    parameter int unsigned MAX_DECIMATION = 16384,
    parameter int unsigned GAIN_WIDTH     = 8,
    localparam int unsigned REGISTER_WIDTH = cic_reg_width(DATA_WIDTH, NUM_STAGES, MAX_DECIMATION),
    localparam int unsigned DEC_WIDTH      = $clog2(MAX_DECIMATION + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [DEC_WIDTH-1:0]  decimation,
    input  logic [GAIN_WIDTH-1:0] gain,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  overrun
);

    localparam int unsigned HEADROOM = REGISTER_WIDTH - DATA_WIDTH;

    typedef logic [REGISTER_WIDTH-1:0] s_register_t;

    s_register_t          integ      [NUM_STAGES];
    s_register_t          comb_data  [NUM_STAGES+1];
    logic                 comb_valid [NUM_STAGES+1];
    s_register_t          cap_data;
    logic                 cap_valid;
    logic [DEC_WIDTH-1:0] count;
    logic [DEC_WIDTH-1:0] r_active;
    logic [DEC_WIDTH-1:0] r_next;

    // Integrator chain, advancing only on qualified input samples.
    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_integ
        s_register_t addend;
        if (k == 0) begin : g_first
            assign addend = REGISTER_WIDTH'(signed'(data_in));
        end else begin : g_rest
            assign addend = integ[k-1];
        end
        always_ff @(posedge clk) begin
            if (rst) begin
                integ[k] <= '0;
            end else if (in_valid) begin
                integ[k] <= integ[k] + addend;
            end
        end
    end

    always_comb begin
        r_next = decimation;
        if (decimation < DEC_WIDTH'(2)) begin
            r_next = DEC_WIDTH'(2);
        end else if (decimation > DEC_WIDTH'(MAX_DECIMATION)) begin
            r_next = DEC_WIDTH'(MAX_DECIMATION);
        end
    end

    // Ratio is only re-latched at a frame boundary so a change never splits a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            r_active  <= r_next;
            cap_data  <= '0;
            cap_valid <= 1'b0;
        end else begin
            cap_valid <= 1'b0;
            if (in_valid) begin
                if (count == r_active - DEC_WIDTH'(1)) begin
                    count     <= '0;
                    r_active  <= r_next;
                    cap_data  <= integ[NUM_STAGES-1];
                    cap_valid <= 1'b1;
                end else begin
                    count <= count + DEC_WIDTH'(1);
                end
            end
        end
    end

    assign comb_data[0]  = cap_data;
    assign comb_valid[0] = cap_valid;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_comb
        cic_comb_stage #(
            .WIDTH(REGISTER_WIDTH)
        ) u_comb (
            .clk      (clk),
            .rst      (rst),
            .in_valid (comb_valid[k]),
            .data_in  (comb_data[k]),
            .out_valid(comb_valid[k+1]),
            .data_out (comb_data[k+1])
        );
    end

    logic signed [REGISTER_WIDTH-1:0] comb_out_s;
    logic signed [REGISTER_WIDTH-1:0] scaled;
    int unsigned                      shift_amt;
    logic [DATA_WIDTH-1:0]            y_c;
    logic                             res_valid;

    // Gain reduces the truncating right shift; the result is floored then saturated.
    always_comb begin
        shift_amt  = (32'(gain) >= HEADROOM) ? 32'd0 : HEADROOM - 32'(gain);
        comb_out_s = signed'(comb_data[NUM_STAGES]);
        scaled     = comb_out_s >>> shift_amt;
        y_c        = DATA_WIDTH'(sat_trunc(SAT_W'(scaled), DATA_WIDTH));
        res_valid  = comb_valid[NUM_STAGES];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (res_valid) begin
            if (!out_valid || out_ready) begin
                data_out  <= y_c;
                out_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cic_decimator_n.sv
// Self-checking bench for cic_decimator_n (12-bit, 3 stages, max ratio 16).
module tb_cic_decimator_n;

    localparam int unsigned DW   = 12;
    localparam int unsigned NS   = 3;
    localparam int unsigned MAXD = 16;
    localparam int unsigned GW   = 8;
    localparam int unsigned DECW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] data_in;
    logic [DECW-1:0] decimation;
    logic [GW-1:0] gain;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] data_out;
    logic          overrun;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    cic_decimator_n #(
        .DATA_WIDTH    (DW),
        .NUM_STAGES    (NS),
        .MAX_DECIMATION(MAXD),
        .GAIN_WIDTH    (GW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .decimation(decimation),
        .gain      (gain),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .overrun   (overrun)
    );

    function automatic int clamp_r(input int d);
        if (d < 2) return 2;
        if (d > int'(MAXD)) return int'(MAXD);
        return d;
    endfunction

    // Settled output for constant input: sat(floor(x * R^N / 2^max(0, 12 - gain))).
    function automatic int model_out(input int x, input int r, input int g);
        longint v;
        int     sh;
        v = longint'(x);
        for (int i = 0; i < int'(NS); i++) v = v * r;
        sh = 12 - g;
        if (sh < 0) sh = 0;
        v = v >>> sh;
        if (v > 2047) v = 2047;
        if (v < -2048) v = -2048;
        return int'(v);
    endfunction

    task automatic wait_pulse(input int budget, input bit toggle, output bit got, output int cycles);
        got    = 1'b0;
        cycles = 0;
        while (!got && cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (out_valid === 1'b1) got = 1'b1;
            if (toggle) in_valid = ~in_valid;
        end
    endtask

    // Constant-input scenario: settle, then check pulse spacing and value.
    task automatic run_dc(input string name, input int x, input int d, input int g, input bit toggle);
        int r, cyc, exp_i, spacing;
        bit got;
        logic [DW-1:0] exp_v;
        r       = clamp_r(d);
        spacing = toggle ? 2 * r : r;
        exp_i   = model_out(x, r, g);
        exp_v   = DW'(exp_i);
        data_in    = DW'(x);
        decimation = DECW'(d);
        gain       = GW'(g);
        in_valid   = 1'b1;
        for (int i = 0; i < 7; i++) begin
            wait_pulse(100, toggle, got, cyc);
            total_cnt++;
            if (!got) begin
                $display("FAIL %s settle pulse %0d: no out_valid within 100 cycles", name, i);
                in_valid = 1'b1;
                return;
            end
            pass_cnt++;
        end
        for (int i = 0; i < 3; i++) begin
            wait_pulse(100, toggle, got, cyc);
            total_cnt++;
            if (!got) begin
                $display("FAIL %s pulse %0d: no out_valid within 100 cycles", name, i);
                in_valid = 1'b1;
                return;
            end
            pass_cnt++;
            total_cnt++;
            if (cyc !== spacing) $display("FAIL %s spacing: got %0d cycles expected %0d", name, cyc, spacing);
            else pass_cnt++;
            total_cnt++;
            if (data_out !== exp_v)
                $display("FAIL %s value: got %0d expected %0d", name, $signed(data_out), exp_i);
            else pass_cnt++;
        end
        in_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        in_valid   = 1'b1;
        data_in    = DW'(100);
        decimation = DECW'(16);
        gain       = '0;
        out_ready  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset out_valid: got %b expected 0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (data_out !== '0) $display("FAIL reset data_out: got %0d expected 0", $signed(data_out));
        else pass_cnt++;
        total_cnt++;
        if (overrun !== 1'b0) $display("FAIL reset overrun: got %b expected 0", overrun);
        else pass_cnt++;
    endtask

    task automatic test_dc_gain();
        run_dc("dc_r16", 100, 16, 0, 1'b0);
        run_dc("gain2", 100, 16, 2, 1'b0);
        run_dc("sat_pos", 2047, 16, 4, 1'b0);
        run_dc("sat_neg", -2048, 16, 4, 1'b0);
        run_dc("clamp_low", 300, 0, 6, 1'b0);
        run_dc("clamp_high", -700, 31, 0, 1'b0);
    endtask

    task automatic test_random();
        int x, d, g;
        for (int n = 0; n < 6; n++) begin
            x = int'($urandom_range(0, 4095)) - 2048;
            d = int'($urandom_range(0, 31));
            g = int'($urandom_range(0, 15));
            run_dc($sformatf("rand%0d", n), x, d, g, 1'b0);
        end
    endtask

    task automatic test_gated_input();
        run_dc("gated", 100, 16, 0, 1'b1);
    endtask

    task automatic test_runtime_ratio();
        bit got;
        int cyc;
        int exp_sp [3] = '{11, 8, 8};
        run_dc("ratio_pre", 100, 16, 0, 1'b0);
        wait_pulse(100, 1'b0, got, cyc);
        repeat (5) @(negedge clk);
        decimation = DECW'(8);
        for (int i = 0; i < 3; i++) begin
            wait_pulse(100, 1'b0, got, cyc);
            total_cnt++;
            if (!got || cyc !== exp_sp[i])
                $display("FAIL ratio_switch spacing %0d: got %0d cycles (seen=%b) expected %0d", i, cyc, got, exp_sp[i]);
            else pass_cnt++;
        end
        run_dc("ratio_r8", 100, 8, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        bit got, held_ok;
        int cyc;
        run_dc("bp_pre", 100, 16, 0, 1'b0);
        wait_pulse(100, 1'b0, got, cyc);
        total_cnt++;
        if (!got) $display("FAIL bp first pulse: no out_valid within 100 cycles");
        else pass_cnt++;
        out_ready = 1'b0;
        data_in   = DW'(300);
        held_ok   = 1'b1;
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || data_out !== DW'(100) || overrun !== 1'b0) held_ok = 1'b0;
        end
        total_cnt++;
        if (!held_ok) $display("FAIL bp hold: got valid=%b data=%0d overrun=%b expected 1/100/0", out_valid, $signed(data_out), overrun);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (overrun !== 1'b1) $display("FAIL bp overrun set: got %b expected 1", overrun);
        else pass_cnt++;
        total_cnt++;
        if (data_out !== DW'(100)) $display("FAIL bp retained: got %0d expected 100", $signed(data_out));
        else pass_cnt++;
        out_ready = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL bp drain out_valid: got %b expected 0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (overrun !== 1'b1) $display("FAIL bp overrun sticky: got %b expected 1", overrun);
        else pass_cnt++;
        data_in = DW'(100);
    endtask

    task automatic test_reset_mid();
        bit got;
        int cyc;
        int v;
        wait_pulse(100, 1'b0, got, cyc);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL rstmid out_valid: got %b expected 0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (data_out !== '0) $display("FAIL rstmid data_out: got %0d expected 0", $signed(data_out));
        else pass_cnt++;
        total_cnt++;
        if (overrun !== 1'b0) $display("FAIL rstmid overrun: got %b expected 0", overrun);
        else pass_cnt++;
        wait_pulse(100, 1'b0, got, cyc);
        v = int'($signed(data_out));
        total_cnt++;
        if (!got || v < 0 || v >= 100)
            $display("FAIL rstmid ramp: got %0d (seen=%b) expected ramp value in [0,100)", v, got);
        else pass_cnt++;
        run_dc("rstmid_settle", 100, 16, 0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_dc_gain();
        test_random();
        test_gated_input();
        test_runtime_ratio();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/cic_decimator_n.md
Name: cic_decimator_n

Overview:
- Generic N-stage CIC decimator, the parametrised successor of the fixed 5-stage CIC in the SDR receive chain (after the NCO/mixer, before the FIR compensator).
- Adds over the fixed-stage version:
  - compile-time stage count and auto-sized registers;
  - runtime decimation ratio;
  - input valid qualifier;
  - synchronous reset;
  - output valid/ready handshake with overrun flag;
  - saturating gain stage.

Parameters:
- DATA_WIDTH, 12: input and output sample width, signed.
- NUM_STAGES, 5: integrator/comb stage count N, legal range 1..8.
- MAX_DECIMATION, 16384: largest supported ratio R; power of two not required.
- GAIN_WIDTH, 8: width of the gain shift control.
- REGISTER_WIDTH (localparam): DATA_WIDTH + NUM_STAGES*$clog2(MAX_DECIMATION).
- DEC_WIDTH (localparam): $clog2(MAX_DECIMATION+1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  data_in is a valid sample this cycle.
- data_in  in  DATA_WIDTH  signed input sample.
- decimation  in  DEC_WIDTH  runtime ratio R.
- gain  in  GAIN_WIDTH  left-shift gain applied before truncation.
- out_valid  out  1  data_out holds an unconsumed sample.
- out_ready  in  1  downstream accepts data_out.
- data_out  out  DATA_WIDTH  signed decimated sample.
- overrun  out  1  sticky: a comb result was dropped.

Behaviour:
- Reset (rst=1 at posedge clk) clears:
  - all integrators, comb delays, pipeline valids and the sample counter;
  - out_valid=0, data_out=0, overrun=0.
  - Reset mid-frame discards partial accumulation; the first output after reset uses fresh state.
- Integrators:
  - Advance only when in_valid=1.
  - Stage 1 adds sign-extended data_in; stage k adds stage k-1.
  - Modulo 2^REGISTER_WIDTH wrap is intended and is exact given the width rule.
- Decimation counter:
  - Increments on each in_valid.
  - When count == R_active-1 and in_valid=1: the last integrator value (including this sample's update path, i.e. the registered value) is captured into comb stage 0 with a valid pulse, and count returns to 0.
- R_active:
  - Latched from the decimation port at reset release and at each wrap, so a ratio change never splits a frame.
  - Values <2 are clamped to 2; values >MAX_DECIMATION are clamped to MAX_DECIMATION.
- Comb pipeline:
  - NUM_STAGES stages, one register per stage, with a valid bit shifting alongside the data.
  - Stage k computes x - x_delayed; its delay register updates only when its input valid=1.
  - Latency from capture to result valid is NUM_STAGES cycles.
  - Minimum input spacing between captures is R>=2 cycles, so no stage collision.
- Output stage (one additional cycle):
  - shift = max(0, REGISTER_WIDTH-DATA_WIDTH-gain); y = comb_out >>> shift (floor, no rounding).
  - y is saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Output handshake (single-entry register):
  - On result valid: if out_valid=0 or out_ready=1 the same cycle, load data_out and set out_valid=1.
  - Otherwise drop the new result, keep the old data_out and set overrun=1.
  - out_valid clears on out_ready when no new result arrives that cycle.
  - overrun clears only on rst.
- DC gain: constant input x gives comb output x*R^N.
- Steady-state check: with R a power of two and R==MAX_DECIMATION, gain=0 reproduces x exactly.

Decomposition:
- Package cic_pkg:
  - function cic_reg_width(data_w, stages, max_dec);
  - saturating-resize function sat_trunc;
  - type s_register_t is parametrised in-module from the localparam.
- Sub-module cic_comb_stage (one differentiator with its valid-gated delay), instantiated NUM_STAGES times via generate.
- Integrators stay inline in a generate loop.

Test Plan:
All cases use DATA_WIDTH=12, NUM_STAGES=3, MAX_DECIMATION=16 (REGISTER_WIDTH=24), out_ready=1 and in_valid=1 unless stated.
- DC gain: data_in=100, R=16, gain=0 -> after settling (>=4 frames) every out_valid pulse carries 100; pulses spaced exactly 16 cycles.
- Gain and saturation:
  - data_in=100, gain=2 -> 400.
  - data_in=2047, gain=4 -> 2047 (saturated).
  - data_in=-2048, gain=4 -> -2048.
- Runtime ratio: switch decimation 16->8 mid-frame -> current frame completes at 16; following pulses every 8 cycles; settled value 100*512>>12 = 12.
- Gated input: in_valid toggling 1,0,1,0 with data_in=100, R=16 -> pulses every 32 cycles, settled value still 100.
- Backpressure: hold out_ready=0 across two result pulses -> first value retained; overrun=1 one cycle after second result; out_ready=1 then clears out_valid.
- Reset mid-operation: assert rst for 1 cycle during a frame -> next cycle out_valid=0, data_out=0, overrun=0; first post-reset result is ramp-up value, not stale data.
